// File: rtl/frame_write_scheduler_if.sv
// Write-side bundle of the frame write scheduler: drawing clients, clear/swap
// handshakes and the registered double-buffer write port.
interface frame_write_scheduler_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 24
);
  logic [9:0]        yPos;
  logic              aReq;
  logic [ADDR_W-1:0] aAddr;
  logic [DATA_W-1:0] aData;
  logic              aGnt;
  logic              bReq;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] bData;
  logic              bGnt;
  logic              clearReq;
  logic [DATA_W-1:0] clearColor;
  logic              clearDone;
  logic              swapReq;
  logic              swapAck;
  logic              frontBank;
  logic              wrEn;
  logic              wrBank;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              busy;

  // Requesting side: render logic, clear/swap control and the VGA line counter.
  modport master (
    output yPos, aReq, aAddr, aData, bReq, bAddr, bData,
           clearReq, clearColor, swapReq,
    input  aGnt, bGnt, clearDone, swapAck, frontBank,
           wrEn, wrBank, wrAddr, wrData, busy
  );

  modport slave (
    input  yPos, aReq, aAddr, aData, bReq, bAddr, bData,
           clearReq, clearColor, swapReq,
    output aGnt, bGnt, clearDone, swapAck, frontBank,
           wrEn, wrBank, wrAddr, wrData, busy
  );
endinterface

// File: rtl/frame_write_scheduler.sv
// Schedules all writes into the VGA double buffer: round-robin client writes,
// back-bank clear, and bank swaps aligned to the start of vertical blanking.
//
// state   | meaning
// RUN     | clients arbitrated round-robin, one write per transfer
// CLEAR   | back bank filled with the latched colour, one word per cycle
// PENDING | swap committed, waiting for the next vblank start
module frame_write_scheduler #(
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 19200,
  parameter int DATA_W   = 24,
  parameter int V_ACTIVE = 480
) (
  input logic clk,
  input logic rstN,
  frame_write_scheduler_if.slave bus
);

  typedef enum logic [1:0] {RUN, CLEAR, PENDING} stateT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [9:0]        VBLANK_LN = 10'(V_ACTIVE);

  stateT             state;
  logic              frontBank;
  logic              lastWinnerB;
  logic [ADDR_W-1:0] clrCnt;
  logic [DATA_W-1:0] clrColor;
  logic [9:0]        yPosD;
  logic              wrEn;
  logic              wrBank;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              swapAck;
  logic              clearDone;
  logic              busy;

  logic vblankStart;
  logic clearEff;
  logic swapEff;
  logic runIdle;
  logic aGnt;
  logic bGnt;

  assign vblankStart = (yPosD != VBLANK_LN) && (bus.yPos == VBLANK_LN);

  // Requests are level-held until their pulse; ignore them in the pulse
  // cycle so a just-finished clear or swap is not restarted.
  assign clearEff = bus.clearReq & ~clearDone;
  assign swapEff  = bus.swapReq & ~swapAck;
  assign runIdle  = rstN & (state == RUN) & ~clearEff & ~swapEff;

  assign aGnt = runIdle & bus.aReq & (~bus.bReq | lastWinnerB);
  assign bGnt = runIdle & bus.bReq & ~aGnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= RUN;
      frontBank   <= 1'b0;
      lastWinnerB <= 1'b1;
      clrCnt      <= '0;
      clrColor    <= '0;
      yPosD       <= '0;
      wrEn        <= 1'b0;
      wrBank      <= 1'b0;
      wrAddr      <= '0;
      wrData      <= '0;
      swapAck     <= 1'b0;
      clearDone   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      yPosD     <= bus.yPos;
      wrEn      <= 1'b0;
      swapAck   <= 1'b0;
      clearDone <= 1'b0;
      case (state)
        RUN: begin
          if (clearEff) begin
            state    <= CLEAR;
            clrColor <= bus.clearColor;
            clrCnt   <= '0;
            busy     <= 1'b1;
          end else if (swapEff) begin
            state <= PENDING;
            busy  <= 1'b1;
          end else if (aGnt) begin
            wrEn        <= 1'b1;
            wrAddr      <= bus.aAddr;
            wrData      <= bus.aData;
            wrBank      <= ~frontBank;
            lastWinnerB <= 1'b0;
          end else if (bGnt) begin
            wrEn        <= 1'b1;
            wrAddr      <= bus.bAddr;
            wrData      <= bus.bData;
            wrBank      <= ~frontBank;
            lastWinnerB <= 1'b1;
          end
        end
        CLEAR: begin
          wrEn   <= 1'b1;
          wrAddr <= clrCnt;
          wrData <= clrColor;
          wrBank <= ~frontBank;
          if (clrCnt == LAST_ADDR) begin
            state     <= RUN;
            busy      <= 1'b0;
            clearDone <= 1'b1;
          end else begin
            clrCnt <= clrCnt + ADDR_W'(1);
          end
        end
        PENDING: begin
          // Entry-cycle vblank was seen while still in RUN, so it waits a frame.
          if (vblankStart) begin
            frontBank <= ~frontBank;
            swapAck   <= 1'b1;
            state     <= RUN;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.aGnt      = aGnt;
  assign bus.bGnt      = bGnt;
  assign bus.frontBank = frontBank;
  assign bus.wrEn      = wrEn;
  assign bus.wrBank    = wrBank;
  assign bus.wrAddr    = wrAddr;
  assign bus.wrData    = wrData;
  assign bus.swapAck   = swapAck;
  assign bus.clearDone = clearDone;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Self-checking bench for frame_write_scheduler (DEPTH reduced to 16).
module tb_frame_write_scheduler;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  frame_write_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  frame_write_scheduler #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .V_ACTIVE(480)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrT;

  typedef struct {
    logic              aReq;
    logic              bReq;
    logic [ADDR_W-1:0] aAddr;
    logic [ADDR_W-1:0] bAddr;
    logic [DATA_W-1:0] aData;
    logic [DATA_W-1:0] bData;
    logic              expA;
    logic              expB;
  } vecT;

  wrT  expQ[$];
  vecT vec[10];
  int  nChecks = 0;
  int  nFail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushClear(input logic [DATA_W-1:0] color);
    for (int k = 0; k < DEPTH; k++) begin
      wrT e;
      e.bank = ~bus.frontBank;
      e.addr = ADDR_W'(k);
      e.data = color;
      expQ.push_back(e);
    end
  endtask

  // Scoreboard: grants push expected writes, the write port pops them.
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.wrEn) begin
        if (expQ.size() == 0) begin
          check("unexpected_write", {bus.wrBank, bus.wrAddr, bus.wrData}, 64'h0);
        end else begin
          wrT e;
          e = expQ.pop_front();
          check("wrAddr", 64'(bus.wrAddr), 64'(e.addr));
          check("wrData", 64'(bus.wrData), 64'(e.data));
          check("wrBank", 64'(bus.wrBank), 64'(e.bank));
        end
      end
      if (bus.aGnt || bus.bGnt)
        check("one_gnt", 64'(bus.aGnt & bus.bGnt), 64'h0);
      if (bus.aReq && bus.aGnt) begin
        wrT e;
        e.bank = ~bus.frontBank; e.addr = bus.aAddr; e.data = bus.aData;
        expQ.push_back(e);
      end
      if (bus.bReq && bus.bGnt) begin
        wrT e;
        e.bank = ~bus.frontBank; e.addr = bus.bAddr; e.data = bus.bData;
        expQ.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  found;
    int  viol;

    // Round-robin table; A wins first after reset since lastWinner=B.
    vec[0] = '{1'b1, 1'b1, 15'h0001, 15'h0002, 24'h111111, 24'h222222, 1'b1, 1'b0};
    vec[1] = '{1'b1, 1'b1, 15'h0003, 15'h0004, 24'h333333, 24'h444444, 1'b0, 1'b1};
    vec[2] = '{1'b1, 1'b1, 15'h0005, 15'h0006, 24'h555555, 24'h666666, 1'b1, 1'b0};
    vec[3] = '{1'b1, 1'b1, 15'h0007, 15'h0008, 24'h777777, 24'h888888, 1'b0, 1'b1};
    vec[4] = '{1'b0, 1'b1, 15'h0000, 15'h0010, 24'h000000, 24'hFF0000, 1'b0, 1'b1};
    vec[5] = '{1'b1, 1'b1, 15'h0100, 15'h0101, 24'h0A0A0A, 24'h0B0B0B, 1'b1, 1'b0};
    vec[6] = '{1'b1, 1'b0, 15'h0102, 15'h0103, 24'h0C0C0C, 24'h0D0D0D, 1'b1, 1'b0};
    vec[7] = '{1'b1, 1'b1, 15'h0104, 15'h0105, 24'h0E0E0E, 24'h0F0F0F, 1'b0, 1'b1};
    vec[8] = '{1'b0, 1'b0, 15'h0106, 15'h0107, 24'h121212, 24'h131313, 1'b0, 1'b0};
    vec[9] = '{1'b1, 1'b1, 15'h7FFF, 15'h4000, 24'hFFFFFF, 24'h800000, 1'b1, 1'b0};

    bus.yPos = 10'd100;
    bus.aReq = 1'b1; bus.bReq = 1'b1;
    bus.aAddr = '0; bus.bAddr = '0; bus.aData = '0; bus.bData = '0;
    bus.clearReq = 1'b0; bus.clearColor = '0; bus.swapReq = 1'b0;

    // Reset state, with requests held to show grants are forced low.
    #3;
    check("rst_aGnt", 64'(bus.aGnt), 64'h0);
    check("rst_bGnt", 64'(bus.bGnt), 64'h0);
    check("rst_outs", 64'({bus.wrEn, bus.wrBank, bus.swapAck, bus.clearDone, bus.busy, bus.frontBank}), 64'h0);
    check("rst_wrAddrData", 64'({bus.wrAddr, bus.wrData}), 64'h0);
    bus.aReq = 1'b0; bus.bReq = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // Tests 1/2: arbitration table.
    for (int i = 0; i < 10; i++) begin
      bus.aReq = vec[i].aReq; bus.bReq = vec[i].bReq;
      bus.aAddr = vec[i].aAddr; bus.bAddr = vec[i].bAddr;
      bus.aData = vec[i].aData; bus.bData = vec[i].bData;
      @(negedge clk);
      check($sformatf("vec%0d_aGnt", i), 64'(bus.aGnt), 64'(vec[i].expA));
      check($sformatf("vec%0d_bGnt", i), 64'(bus.bGnt), 64'(vec[i].expB));
      tick();
    end
    bus.aReq = 1'b0; bus.bReq = 1'b0;
    repeat (3) tick();
    check("table_drain", 64'(expQ.size()), 64'h0);

    // Test 3: clear while A requests.
    bus.aReq = 1'b1; bus.aAddr = 15'h0123; bus.aData = 24'hABCDEF;
    bus.clearColor = 24'h00FF00; bus.clearReq = 1'b1;
    pushClear(24'h00FF00);
    found = 1'b0; viol = 0; c = 0;
    while (!found && c < 40) begin
      @(negedge clk);
      if (bus.clearDone) begin
        found = 1'b1;
        check("clear_cycles", 64'(c), 64'd17);
        check("gnt_after_clear", 64'(bus.aGnt), 64'h1);
      end else begin
        if (bus.aGnt) viol++;
        c++;
      end
      tick();
    end
    bus.clearReq = 1'b0; bus.aReq = 1'b0;
    check("clear_done_seen", 64'(found), 64'h1);
    check("clear_no_gnt", 64'(viol), 64'h0);
    @(negedge clk);
    check("clear_done_pulse", 64'(bus.clearDone), 64'h0);
    repeat (3) tick();
    check("clear_drain", 64'(expQ.size()), 64'h0);

    // Test 4: swap waits for yPos reaching 480.
    bus.swapReq = 1'b1; bus.aReq = 1'b1; bus.aAddr = 15'h0200; bus.aData = 24'h123456;
    viol = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.aGnt || bus.bGnt || bus.wrEn || bus.swapAck) viol++;
      tick();
    end
    check("pend_quiet", 64'(viol), 64'h0);
    check("pend_busy", 64'(bus.busy), 64'h1);
    bus.yPos = 10'd480;
    @(negedge clk);
    check("swap_early", 64'({bus.swapAck, bus.frontBank}), 64'h0);
    tick();
    @(negedge clk);
    check("swap_ack", 64'(bus.swapAck), 64'h1);
    check("swap_front", 64'(bus.frontBank), 64'h1);
    check("swap_gnt", 64'(bus.aGnt), 64'h1);
    tick();
    bus.swapReq = 1'b0; bus.aReq = 1'b0;
    @(negedge clk);
    check("post_swap_wrEn", 64'(bus.wrEn), 64'h1);
    check("post_swap_bank", 64'(bus.wrBank), 64'h0);
    check("swap_ack_pulse", 64'(bus.swapAck), 64'h0);
    tick();
    bus.yPos = 10'd100;
    repeat (2) tick();
    check("swap_drain", 64'(expQ.size()), 64'h0);

    // Test 6: async reset mid-clear with frontBank=1.
    bus.clearColor = 24'h0000FF; bus.clearReq = 1'b1;
    pushClear(24'h0000FF);
    found = 1'b0; c = 0;
    while (!found && c < 40) begin
      @(negedge clk);
      if (bus.wrEn && bus.wrAddr == 15'd6) found = 1'b1;
      else begin
        c++;
        tick();
      end
    end
    check("mid_clear_reached", 64'(found), 64'h1);
    #2 rstN = 1'b0;
    #1;
    check("mid_rst_outs", 64'({bus.wrEn, bus.wrBank, bus.swapAck, bus.clearDone, bus.busy, bus.frontBank}), 64'h0);
    check("mid_rst_wrAddrData", 64'({bus.wrAddr, bus.wrData}), 64'h0);
    expQ.delete();
    bus.clearReq = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wrEn || bus.busy) viol++;
    end
    check("post_rst_idle", 64'(viol), 64'h0);
    tick();

    // Test 5: clear and swap together; clear first, swap at next vblank.
    bus.clearColor = 24'h00FF00; bus.clearReq = 1'b1; bus.swapReq = 1'b1;
    pushClear(24'h00FF00);
    found = 1'b0; c = 0; viol = 0;
    while (!found && c < 40) begin
      @(negedge clk);
      if (bus.swapAck) viol++;
      if (bus.clearDone) found = 1'b1;
      else c++;
      tick();
    end
    bus.clearReq = 1'b0;
    check("cs_clear_done", 64'(found), 64'h1);
    check("cs_no_early_ack", 64'(viol), 64'h0);
    viol = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.swapAck || bus.wrEn || bus.aGnt || bus.bGnt) viol++;
      tick();
    end
    check("cs_pending_quiet", 64'(viol), 64'h0);
    check("cs_busy", 64'(bus.busy), 64'h1);
    check("cs_drain", 64'(expQ.size()), 64'h0);
    bus.yPos = 10'd480;
    tick();
    @(negedge clk);
    check("cs_swap_ack", 64'({bus.swapAck, bus.frontBank}), 64'h3);
    tick();
    bus.swapReq = 1'b0;

    // Test 7: vblank start in the cycle the swap is accepted is missed.
    bus.yPos = 10'd479;
    tick();
    bus.yPos = 10'd480; bus.swapReq = 1'b1;
    viol = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.swapAck) viol++;
      tick();
    end
    check("entry_vblank_missed", 64'(viol), 64'h0);
    check("entry_front_hold", 64'(bus.frontBank), 64'h1);
    bus.yPos = 10'd100;
    tick();
    bus.yPos = 10'd480;
    tick();
    @(negedge clk);
    check("entry_next_ack", 64'({bus.swapAck, bus.frontBank}), 64'h2);
    tick();
    bus.swapReq = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/frame_write_scheduler.md
Name: frame_write_scheduler

Overview:
Sequences all writes into the VGA double buffer and decides when the front and back banks swap. Two drawing clients (A and B) share the single buffer write port under round-robin arbitration. A clear engine fills the back bank with one colour. Swaps happen only at the start of vertical blanking, taken from the yPos counter of the VGA controller. Sits between game/render logic and the double buffer, in the 25 MHz pixel clock domain.

Parameters:
ADDR_W, 15, back-buffer word address width
DEPTH, 19200, words per bank (160x120); clear walks 0..DEPTH-1
DATA_W, 24, pixel word width ({R,G,B} 8 bits each)
V_ACTIVE, 480, first non-visible line value of yPos

Ports:
clk  in  1  pixel clock (25 MHz)
rstN  in  1  asynchronous active-low reset
yPos  in  10  current VGA line from the controller
aReq  in  1  client A write request (level, held until aGnt)
aAddr  in  ADDR_W  client A address
aData  in  DATA_W  client A pixel
aGnt  out  1  client A accept (combinational; transfer when aReq&aGnt)
bReq, bAddr, bData, bGnt  same as A, for client B
clearReq  in  1  start back-bank clear (level, held until clearDone)
clearColor  in  DATA_W  fill value, sampled when the clear starts
clearDone  out  1  1-cycle pulse after the last clear write is issued
swapReq  in  1  request bank swap (level, held until swapAck)
swapAck  out  1  1-cycle pulse in the cycle frontBank toggles
frontBank  out  1  bank currently read by VGA
wrEn  out  1  buffer write strobe (registered)
wrBank  out  1  bank written (always ~frontBank at issue time)
wrAddr  out  ADDR_W  buffer write address (registered)
wrData  out  DATA_W  buffer write data (registered)
busy  out  1  high in CLEAR or PENDING

Behaviour:
- Reset (rstN=0, async): state=RUN, frontBank=0, lastWinner=B (so A wins first), clear counter=0, yPos history register=0. All outputs 0: wrEn, wrAddr, wrData, wrBank, swapAck, clearDone, busy, aGnt, bGnt.
- vblankStart: one-cycle internal strobe, asserted when registered yPos_d != V_ACTIVE and yPos == V_ACTIVE.
- State RUN:
  - Priority: clearReq (-> CLEAR, latch clearColor, counter=0) over swapReq (-> PENDING) over arbitration.
  - Grants are asserted only in RUN, only when neither clearReq nor swapReq is high.
  - Round-robin arbitration: if exactly one client requests, it wins. If both request, the client that did not win last time wins. lastWinner updates on every transfer.
  - At most one gnt high per cycle.
- Write latency: a transfer in cycle N produces wrEn=1 with that client's wrAddr/wrData in cycle N+1. wrBank=~frontBank as sampled in cycle N. wrEn=0 in every other cycle.
- State CLEAR:
  - Issues one write per cycle: wrAddr=counter, wrData=latched colour. Both grants held at 0.
  - The counter increments from 0 to DEPTH-1, giving exactly DEPTH writes.
  - The cycle after the write with counter=DEPTH-1 is issued: clearDone pulses and state returns to RUN.
  - clearReq dropping mid-clear does not abort the clear.
  - The pending swapReq is evaluated in RUN afterwards.
- State PENDING:
  - No grants, no writes.
  - On vblankStart: frontBank toggles, swapAck pulses in the same cycle, state returns to RUN.
  - If vblankStart coincides with the PENDING entry cycle, the swap waits for the next frame.
  - swapReq dropping before the ack leaves the swap committed anyway.
- swapAck and clearDone never assert together; a clear cannot start while a swap is pending.
- busy = (state != RUN), registered alongside the state.
- Counter width is ADDR_W. DEPTH must be <= 2^ADDR_W. There is no wrap-around beyond DEPTH-1.

Test Plan:
1. Reset, then aReq and bReq held high for 4 cycles -> grants alternate A,B,A,B. wrEn is high on the 4 following cycles with the matching addr/data, wrBank=1.
2. Only bReq high with bAddr=0x0010, bData=0xFF0000 -> bGnt=1 the same cycle. Next cycle wrEn=1, wrAddr=0x0010, wrData=0xFF0000, aGnt stays 0.
3. DEPTH=16, clearReq with clearColor=0x00FF00 while aReq is high -> aGnt=0 for the whole clear. 16 consecutive writes to addresses 0..15 with 0x00FF00. clearDone pulses once; A is granted the cycle after.
4. swapReq raised with yPos=100, then yPos stepped to 480 -> no grants or writes until yPos hits 480. swapAck and the frontBank 0->1 toggle land in that cycle; subsequent writes use wrBank=0.
5. clearReq and swapReq rise together -> CLEAR runs fully first, then PENDING. swapAck comes only at the next vblankStart after clearDone.
6. rstN pulsed low mid-clear at counter=7 and with frontBank=1 -> outputs go 0 immediately and frontBank=0. After release the state is RUN and no further clear writes occur unless clearReq is held.
